metrics_scheduler: RTL and testbench

Shares one iterative restoring divider between the two metric calculations of the typing test: accuracy (`completed_digits*100/(completed_digits+missed)`) and words per minute (`total_words*60/elapsed_time`). Each calculation is a request channel. The block latches requests, arbitrates them round-robin and runs one division at a time. It then converts each quotient to two BCD display digits. It sits between the game controller, which raises the requests and owns the counters, and the accuracy/result digit muxes feeding the 7-segment driver.

---
 rtl/metrics_scheduler_if.sv | 34 +++
 rtl/metrics_scheduler.sv | 146 ++++++++++++++
 tb/tb_metrics_scheduler.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/metrics_scheduler_if.sv
// Request/result bundle between the game controller (master) and metrics_scheduler (slave).
// acc_req/wpm_req have no ready: any high edge marks the channel pending; *_valid is a one-cycle pulse with no back-pressure.
interface metrics_scheduler_if #(
    parameter int WIDTH = 16
);
    logic             acc_req;
    logic [WIDTH-1:0] completed_digits;
    logic [WIDTH-1:0] missed;
    logic             wpm_req;
    logic [WIDTH-1:0] total_words;
    logic [WIDTH-1:0] elapsed_time;
    logic             busy;
    logic             acc_valid;
    logic             acc_full;
    logic [3:0]       acc_tens;
    logic [3:0]       acc_ones;
    logic             wpm_valid;
    logic             wpm_sat;
    logic [3:0]       wpm_tens;
    logic [3:0]       wpm_ones;
    logic [1:0]       state_dbg;

    modport master (
        output acc_req, completed_digits, missed, wpm_req, total_words, elapsed_time,
        input  busy, acc_valid, acc_full, acc_tens, acc_ones,
        input  wpm_valid, wpm_sat, wpm_tens, wpm_ones, state_dbg
    );

    modport slave (
        input  acc_req, completed_digits, missed, wpm_req, total_words, elapsed_time,
        output busy, acc_valid, acc_full, acc_tens, acc_ones,
        output wpm_valid, wpm_sat, wpm_tens, wpm_ones, state_dbg
    );
endinterface

// File: rtl/metrics_scheduler.sv
// Shares one restoring divider between the accuracy and WPM requests (round-robin),
// then splits each quotient into two BCD digits for the 7-segment muxes.
module metrics_scheduler #(
    parameter int WIDTH = 16
) (
    input logic               clk,
    input logic               rst,
    metrics_scheduler_if.slave bus
);
    localparam int N  = WIDTH + 7;
    localparam int RW = WIDTH + 2;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_CONV = 2'd2
    } state_t;

    state_t         state;
    logic           pend_acc, pend_wpm, last_wpm, job_wpm, div_zero;
    logic [N-1:0]   dvd;
    logic [WIDTH:0] dvs;
    logic [RW-1:0]  rem;
    logic [CW-1:0]  cnt;
    logic           busy_r, acc_valid_r, acc_full_r, wpm_valid_r, wpm_sat_r;
    logic [3:0]     acc_tens_r, acc_ones_r, wpm_tens_r, wpm_ones_r;

    logic           elig_acc, elig_wpm, grant, grant_wpm, take;
    logic           acc_is_full, wpm_is_sat;
    logic [WIDTH:0] acc_dvs, new_dvs;
    logic [N-1:0]   new_dvd;
    logic [RW-1:0]  rem_sh, rem_sub, dvs_ext;
    logic [7:0]     q_bcd;

    // Compare chain: the first multiple of ten not exceeding v gives the tens digit.
    function automatic logic [7:0] bcd_split(input logic [6:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'd0;
        ones = v[3:0];
        for (int k = 9; k >= 1; k--) begin
            if (tens == 4'd0 && v >= 7'(k * 10)) begin
                tens = 4'(k);
                ones = 4'(v - 7'(k * 10));
            end
        end
        return {tens, ones};
    endfunction

    always_comb begin
        elig_acc    = pend_acc | bus.acc_req;
        elig_wpm    = pend_wpm | bus.wpm_req;
        grant       = (state == S_IDLE) && (elig_acc || elig_wpm);
        grant_wpm   = elig_wpm && (!elig_acc || !last_wpm);
        acc_dvs     = {1'b0, bus.completed_digits} + {1'b0, bus.missed};
        new_dvs     = grant_wpm ? {1'b0, bus.elapsed_time} : acc_dvs;
        new_dvd     = grant_wpm ? N'(bus.total_words) * N'(60)
                                : N'(bus.completed_digits) * N'(100);
        rem_sh      = (rem << 1) | RW'(dvd[N-1]);
        dvs_ext     = RW'(dvs);
        take        = rem_sh >= dvs_ext;
        rem_sub     = rem_sh - dvs_ext;
        acc_is_full = div_zero || (dvd >= N'(100));
        wpm_is_sat  = div_zero || (dvd > N'(99));
        q_bcd       = bcd_split(dvd[6:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pend_acc    <= 1'b0;
            pend_wpm    <= 1'b0;
            last_wpm    <= 1'b1;
            job_wpm     <= 1'b0;
            div_zero    <= 1'b0;
            dvd         <= '0;
            dvs         <= '0;
            rem         <= '0;
            cnt         <= '0;
            busy_r      <= 1'b0;
            acc_valid_r <= 1'b0;
            wpm_valid_r <= 1'b0;
            acc_full_r  <= 1'b1;
            acc_tens_r  <= 4'hA;
            acc_ones_r  <= 4'hA;
            wpm_sat_r   <= 1'b0;
            wpm_tens_r  <= 4'd0;
            wpm_ones_r  <= 4'd0;
        end else begin
            acc_valid_r <= 1'b0;
            wpm_valid_r <= 1'b0;
            // A request on its own grant edge re-arms the flag, so that channel runs again.
            pend_acc <= bus.acc_req | (pend_acc & ~(grant & ~grant_wpm));
            pend_wpm <= bus.wpm_req | (pend_wpm & ~(grant & grant_wpm));
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        job_wpm  <= grant_wpm;
                        last_wpm <= grant_wpm;
                        dvd      <= new_dvd;
                        dvs      <= new_dvs;
                        rem      <= '0;
                        cnt      <= '0;
                        div_zero <= (new_dvs == '0);
                        busy_r   <= 1'b1;
                        state    <= (new_dvs == '0) ? S_CONV : S_DIV;
                    end
                end
                S_DIV: begin
                    rem <= take ? rem_sub : rem_sh;
                    dvd <= {dvd[N-2:0], take};
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) state <= S_CONV;
                end
                S_CONV: begin
                    busy_r <= 1'b0;
                    state  <= S_IDLE;
                    if (job_wpm) begin
                        wpm_valid_r <= 1'b1;
                        wpm_sat_r   <= wpm_is_sat;
                        wpm_tens_r  <= wpm_is_sat ? 4'd9 : q_bcd[7:4];
                        wpm_ones_r  <= wpm_is_sat ? 4'd9 : q_bcd[3:0];
                    end else begin
                        acc_valid_r <= 1'b1;
                        acc_full_r  <= acc_is_full;
                        acc_tens_r  <= acc_is_full ? 4'hA : q_bcd[7:4];
                        acc_ones_r  <= acc_is_full ? 4'hA : q_bcd[3:0];
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.acc_valid = acc_valid_r;
    assign bus.acc_full  = acc_full_r;
    assign bus.acc_tens  = acc_tens_r;
    assign bus.acc_ones  = acc_ones_r;
    assign bus.wpm_valid = wpm_valid_r;
    assign bus.wpm_sat   = wpm_sat_r;
    assign bus.wpm_tens  = wpm_tens_r;
    assign bus.wpm_ones  = wpm_ones_r;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_metrics_scheduler.sv
// Directed bench for metrics_scheduler: arithmetic model of each metric, expected-result
// queues tagged with the cycle the valid must appear, and a per-cycle output compare.
module tb_metrics_scheduler;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  metrics_scheduler_if #(.WIDTH(WIDTH)) bus();
  metrics_scheduler #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad = 0;
  logic [15:0] cyc = 16'd0;
  logic chk_en = 1'b0;
  // Entry layout: {cycle[15:0], flag, tens[3:0], ones[3:0]}
  logic [24:0] exp_acc_q[$];
  logic [24:0] exp_wpm_q[$];
  logic [24:0] e_acc, e_wpm;
  logic [8:0] m_acc = 9'h1AA;
  logic [8:0] m_wpm = 9'h000;

  always @(posedge clk) cyc <= cyc + 16'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Accuracy: percentage of correct keypresses; an empty test counts as 100.
  function automatic logic [8:0] acc_model(input int cd, input int ms);
    int q;
    q = (cd + ms == 0) ? 100 : (cd * 100) / (cd + ms);
    if (q >= 100) return 9'h1AA;
    return {1'b0, 4'(q / 10), 4'(q % 10)};
  endfunction

  // WPM: words*60/seconds, clamped to a two-digit display.
  function automatic logic [8:0] wpm_model(input int tw, input int el);
    int q;
    q = (el == 0) ? 1000 : (tw * 60) / el;
    if (q > 99) return 9'h199;
    return {1'b0, 4'(q / 10), 4'(q % 10)};
  endfunction

  task automatic push_acc(input int cd, input int ms, input int at);
    exp_acc_q.push_back({16'(at), acc_model(cd, ms)});
  endtask

  task automatic push_wpm(input int tw, input int el, input int at);
    exp_wpm_q.push_back({16'(at), wpm_model(tw, el)});
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (bus.acc_valid) begin
        check("acc_valid_expected", 32'(exp_acc_q.size() != 0), 32'd1);
        if (exp_acc_q.size() != 0) begin
          e_acc = exp_acc_q.pop_front();
          check("acc_valid_cycle", 32'(cyc), 32'(e_acc[24:9]));
          m_acc = e_acc[8:0];
        end
      end
      if (bus.wpm_valid) begin
        check("wpm_valid_expected", 32'(exp_wpm_q.size() != 0), 32'd1);
        if (exp_wpm_q.size() != 0) begin
          e_wpm = exp_wpm_q.pop_front();
          check("wpm_valid_cycle", 32'(cyc), 32'(e_wpm[24:9]));
          m_wpm = e_wpm[8:0];
        end
      end
      check("valid_overlap", 32'(bus.acc_valid & bus.wpm_valid), 32'd0);
      check("acc_outputs", 32'({bus.acc_full, bus.acc_tens, bus.acc_ones}), 32'(m_acc));
      check("wpm_outputs", 32'({bus.wpm_sat, bus.wpm_tens, bus.wpm_ones}), 32'(m_wpm));
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_acc"}, 32'({bus.acc_full, bus.acc_tens, bus.acc_ones}), 32'h1AA);
    check({tag, "_wpm"}, 32'({bus.wpm_sat, bus.wpm_tens, bus.wpm_ones}), 32'h000);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_valids"}, 32'({bus.acc_valid, bus.wpm_valid}), 32'd0);
    check({tag, "_state"}, 32'(bus.state_dbg), 32'd0);
  endtask

  task automatic model_reset();
    m_acc = 9'h1AA;
    m_wpm = 9'h000;
    exp_acc_q.delete();
    exp_wpm_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    chk_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_values("reset");
    model_reset();
    chk_en = 1'b1;
  endtask

  // Returns t0 = cycle count just after the edge that samples the request (edge 0).
  task automatic pulse(input logic a, input logic w, output int t0);
    @(negedge clk);
    bus.acc_req = a;
    bus.wpm_req = w;
    @(posedge clk);
    #1;
    t0 = int'(cyc);
    bus.acc_req = 1'b0;
    bus.wpm_req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_acc_q.size() != 0 || exp_wpm_q.size() != 0) && n < 400) begin
      @(posedge clk);
      n++;
    end
    check("drain_in_time", 32'(n < 400), 32'd1);
    exp_acc_q.delete();
    exp_wpm_q.delete();
    repeat (60) @(posedge clk);
    #1;
    check("drain_idle", 32'({bus.busy, bus.state_dbg}), 32'd0);
  endtask

  task automatic set_acc(input int cd, input int ms);
    bus.completed_digits = 16'(cd);
    bus.missed = 16'(ms);
  endtask

  task automatic set_wpm(input int tw, input int el);
    bus.total_words = 16'(tw);
    bus.elapsed_time = 16'(el);
  endtask

  int t0;
  int quiet_bad;

  initial begin
    bus.acc_req = 1'b0;
    bus.wpm_req = 1'b0;
    set_acc(0, 0);
    set_wpm(0, 1);

    check("model_acc_45_5", 32'(acc_model(45, 5)), 32'h090);
    check("model_acc_2_1", 32'(acc_model(2, 1)), 32'h066);
    check("model_acc_0_0", 32'(acc_model(0, 0)), 32'h1AA);
    check("model_wpm_10_8", 32'(wpm_model(10, 8)), 32'h075);
    check("model_wpm_50_20", 32'(wpm_model(50, 20)), 32'h199);
    check("model_wpm_7_5", 32'(wpm_model(7, 5)), 32'h084);

    do_reset();

    // Accuracy 45/(45+5) = 90; the pulse on its own grant edge re-arms one more run.
    set_acc(45, 5);
    pulse(1'b1, 1'b0, t0);
    push_acc(45, 5, t0 + 24);
    push_acc(45, 5, t0 + 49);
    check("busy_edge0", 32'(bus.busy), 32'd1);
    for (int k = 1; k <= 23; k++) begin
      @(posedge clk);
      #1;
      check("busy_div", 32'(bus.busy), 32'd1);
    end
    @(posedge clk);
    #1;
    check("busy_after_conv", 32'(bus.busy), 32'd0);
    check("acc_valid_edge24", 32'(bus.acc_valid), 32'd1);
    drain();
    check("acc_90", 32'({bus.acc_full, bus.acc_tens, bus.acc_ones}), 32'h090);

    // Zero divisor shortcut, then 2/3 -> 66.
    set_acc(0, 0);
    pulse(1'b1, 1'b0, t0);
    push_acc(0, 0, t0 + 1);
    push_acc(0, 0, t0 + 3);
    @(posedge clk);
    #1;
    check("acc_zero_valid_edge1", 32'(bus.acc_valid), 32'd1);
    drain();
    check("acc_full_zero", 32'({bus.acc_full, bus.acc_tens, bus.acc_ones}), 32'h1AA);
    set_acc(2, 1);
    pulse(1'b1, 1'b0, t0);
    push_acc(2, 1, t0 + 24);
    push_acc(2, 1, t0 + 49);
    drain();
    check("acc_66", 32'({bus.acc_full, bus.acc_tens, bus.acc_ones}), 32'h066);

    // WPM cases: 75, zero time, clamped 150, then 84.
    set_wpm(10, 8);
    pulse(1'b0, 1'b1, t0);
    push_wpm(10, 8, t0 + 24);
    push_wpm(10, 8, t0 + 49);
    drain();
    check("wpm_75", 32'({bus.wpm_sat, bus.wpm_tens, bus.wpm_ones}), 32'h075);
    set_wpm(7, 0);
    pulse(1'b0, 1'b1, t0);
    push_wpm(7, 0, t0 + 1);
    push_wpm(7, 0, t0 + 3);
    @(posedge clk);
    #1;
    check("wpm_zero_valid_edge1", 32'(bus.wpm_valid), 32'd1);
    drain();
    check("wpm_zero_sat", 32'({bus.wpm_sat, bus.wpm_tens, bus.wpm_ones}), 32'h199);
    set_wpm(50, 20);
    pulse(1'b0, 1'b1, t0);
    push_wpm(50, 20, t0 + 24);
    push_wpm(50, 20, t0 + 49);
    drain();
    check("wpm_150_sat", 32'({bus.wpm_sat, bus.wpm_tens, bus.wpm_ones}), 32'h199);
    set_wpm(7, 5);
    pulse(1'b0, 1'b1, t0);
    push_wpm(7, 5, t0 + 24);
    push_wpm(7, 5, t0 + 49);
    drain();
    check("wpm_84", 32'({bus.wpm_sat, bus.wpm_tens, bus.wpm_ones}), 32'h084);

    // Simultaneous requests after reset: accuracy first, WPM next, then the re-armed accuracy.
    do_reset();
    set_acc(45, 5);
    set_wpm(10, 8);
    pulse(1'b1, 1'b1, t0);
    push_acc(45, 5, t0 + 24);
    push_wpm(10, 8, t0 + 49);
    push_acc(45, 5, t0 + 74);
    drain();
    // Accuracy was granted last, so WPM wins this tie.
    set_acc(2, 1);
    set_wpm(7, 5);
    pulse(1'b1, 1'b1, t0);
    push_wpm(7, 5, t0 + 24);
    push_acc(2, 1, t0 + 49);
    push_wpm(7, 5, t0 + 74);
    drain();

    // Three accuracy pulses during a WPM job collapse into one job with grant-time operands.
    set_wpm(9, 10);
    set_acc(1, 1);
    pulse(1'b0, 1'b1, t0);
    push_wpm(9, 10, t0 + 24);
    push_acc(30, 10, t0 + 49);
    push_wpm(9, 10, t0 + 74);
    for (int p = 0; p < 3; p++) begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      bus.acc_req = 1'b1;
      @(posedge clk);
      #1;
      bus.acc_req = 1'b0;
    end
    @(negedge clk);
    set_acc(30, 10);
    drain();
    check("acc_75_grant_operands", 32'({bus.acc_full, bus.acc_tens, bus.acc_ones}), 32'h075);

    // Reset on edge 10 of an accuracy job aborts it and clears pending work.
    set_acc(45, 5);
    pulse(1'b1, 1'b0, t0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_values("midjob_reset");
    model_reset();
    chk_en = 1'b1;
    quiet_bad = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      if (bus.busy !== 1'b0) quiet_bad++;
    end
    check("no_job_after_reset", 32'(quiet_bad), 32'd0);
    set_acc(3, 1);
    pulse(1'b1, 1'b0, t0);
    push_acc(3, 1, t0 + 24);
    push_acc(3, 1, t0 + 49);
    drain();
    check("acc_75_after_reset", 32'({bus.acc_full, bus.acc_tens, bus.acc_ones}), 32'h075);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
